// File: rtl/pipe_data_path_fwd.sv
// Five-stage MIPS datapath (F/D/E/M/WB) with its own register file and ALU,
// operand forwarding, load-use / branch-operand stalls and D-stage branch resolution.
module pipe_data_path_fwd #(
    parameter int          DATA_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          FWD_EN   = 1'b1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [31:0]       instr_i,
    input  logic [DATA_W-1:0] read_data_i,
    input  logic              reg_write_d_i,
    input  logic              mem_to_reg_d_i,
    input  logic              mem_write_d_i,
    input  logic              alu_src_d_i,
    input  logic              reg_dst_d_i,
    input  logic              shift_d_i,
    input  logic              branch_eq_d_i,
    input  logic              branch_ne_d_i,
    input  logic              jump_d_i,
    input  logic [2:0]        alu_ctrl_d_i,
    output logic [31:0]       pc_o,
    output logic [31:0]       instr_d_o,
    output logic [DATA_W-1:0] alu_out_o,
    output logic [DATA_W-1:0] write_data_o,
    output logic              mem_write_o,
    output logic              stall_o,
    output logic              flush_o
);

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic              mem_write;
        logic              alu_src;
        logic              shift;
        logic [2:0]        alu_ctrl;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        dest;
        logic [4:0]        shamt;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
    } de_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic              mem_write;
        logic [4:0]        dest;
        logic [DATA_W-1:0] alu_out;
        logic [DATA_W-1:0] wdata;
    } em_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic [4:0]        dest;
        logic [DATA_W-1:0] alu_out;
        logic [DATA_W-1:0] rdata;
    } mw_t;

    // A hazard only exists against a live writer of a non-zero register.
    function automatic logic hits(input logic we, input logic [4:0] dst, input logic [4:0] src);
        return we && (dst != 5'd0) && (dst == src);
    endfunction

    function automatic logic signed [DATA_W-1:0] alu(input logic [2:0] op,
                                                     input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
        logic signed [DATA_W-1:0] r;
        r = '0;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r[0] = (a < b);
            3'd6: r = a << b[4:0];
            default: r = a >> b[4:0];
        endcase
        return r;
    endfunction

    logic [31:0]       pc_q, pc_d, pc_plus4_p0;
    logic [31:0]       instr_p1_q, instr_p1_d, pc4_p1_q, pc4_p1_d;
    de_t               de_p2_q, de_p2_d;
    em_t               em_p3_q, em_p3_d;
    mw_t               mw_p4_q, mw_p4_d;
    logic [DATA_W-1:0] rf_q [32];

    logic [4:0]               rs_p1, rt_p1, rd_p1;
    logic signed [DATA_W-1:0] imm_p1, rd1_p1, rd2_p1, br_a_p1, br_b_p1;
    logic [31:0]              br_tgt_p1, jmp_tgt_p1, target_p1;
    logic                     branch_p1, use_rs_p1, use_rt_p1, taken_p1;
    logic                     hit_e_p1, hit_m_p1, hit_w_p1, stall, flush;
    logic signed [DATA_W-1:0] fwd_a_p2, fwd_b_p2, src_a_p2, src_b_p2, result_p4;

    assign pc_plus4_p0 = pc_q + 32'd4;
    assign result_p4   = mw_p4_q.mem_to_reg ? mw_p4_q.rdata : mw_p4_q.alu_out;

    // ---- D stage: register read, branch resolution, hazard detection ----
    assign rs_p1  = instr_p1_q[25:21];
    assign rt_p1  = instr_p1_q[20:16];
    assign rd_p1  = instr_p1_q[15:11];
    assign imm_p1 = {{(DATA_W-16){instr_p1_q[15]}}, instr_p1_q[15:0]};

    always_comb begin
        rd1_p1 = rf_q[rs_p1];
        rd2_p1 = rf_q[rt_p1];
        if (rs_p1 == 5'd0)                               rd1_p1 = '0;
        else if (hits(mw_p4_q.reg_write, mw_p4_q.dest, rs_p1)) rd1_p1 = result_p4;
        if (rt_p1 == 5'd0)                               rd2_p1 = '0;
        else if (hits(mw_p4_q.reg_write, mw_p4_q.dest, rt_p1)) rd2_p1 = result_p4;
    end

    // Branch compare only forwards ALU results from M; loads in M stall instead.
    always_comb begin
        br_a_p1 = rd1_p1;
        br_b_p1 = rd2_p1;
        if (FWD_EN && !em_p3_q.mem_to_reg) begin
            if (hits(em_p3_q.reg_write, em_p3_q.dest, rs_p1)) br_a_p1 = em_p3_q.alu_out;
            if (hits(em_p3_q.reg_write, em_p3_q.dest, rt_p1)) br_b_p1 = em_p3_q.alu_out;
        end
    end

    assign branch_p1  = branch_eq_d_i | branch_ne_d_i;
    assign taken_p1   = (branch_eq_d_i && (br_a_p1 == br_b_p1)) ||
                        (branch_ne_d_i && (br_a_p1 != br_b_p1)) || jump_d_i;
    assign br_tgt_p1  = pc4_p1_q + {imm_p1[29:0], 2'b00};
    assign jmp_tgt_p1 = {pc4_p1_q[31:28], instr_p1_q[25:0], 2'b00};
    assign target_p1  = jump_d_i ? jmp_tgt_p1 : br_tgt_p1;

    // The rs field of a jump is part of its target, so it is never a source.
    assign use_rs_p1 = !jump_d_i;
    assign use_rt_p1 = !alu_src_d_i || mem_write_d_i || branch_p1 || shift_d_i;
    assign hit_e_p1  = (use_rs_p1 && hits(de_p2_q.reg_write, de_p2_q.dest, rs_p1)) ||
                       (use_rt_p1 && hits(de_p2_q.reg_write, de_p2_q.dest, rt_p1));
    assign hit_m_p1  = (use_rs_p1 && hits(em_p3_q.reg_write, em_p3_q.dest, rs_p1)) ||
                       (use_rt_p1 && hits(em_p3_q.reg_write, em_p3_q.dest, rt_p1));
    assign hit_w_p1  = (use_rs_p1 && hits(mw_p4_q.reg_write, mw_p4_q.dest, rs_p1)) ||
                       (use_rt_p1 && hits(mw_p4_q.reg_write, mw_p4_q.dest, rt_p1));

    always_comb begin
        if (FWD_EN)
            stall = (de_p2_q.mem_to_reg && hit_e_p1) ||
                    (branch_p1 && (hit_e_p1 || (em_p3_q.mem_to_reg && hit_m_p1)));
        else
            stall = hit_e_p1 || hit_m_p1 || hit_w_p1;
    end

    assign flush = taken_p1 && !stall;

    always_comb begin
        pc_d       = pc_plus4_p0;
        instr_p1_d = instr_i;
        pc4_p1_d   = pc_plus4_p0;
        if (stall) begin
            pc_d       = pc_q;
            instr_p1_d = instr_p1_q;
            pc4_p1_d   = pc4_p1_q;
        end else if (flush) begin
            pc_d       = target_p1;
            instr_p1_d = '0;
            pc4_p1_d   = '0;
        end
    end

    always_comb begin
        de_p2_d = '0;
        if (!stall) begin
            de_p2_d.reg_write  = reg_write_d_i;
            de_p2_d.mem_to_reg = mem_to_reg_d_i;
            de_p2_d.mem_write  = mem_write_d_i;
            de_p2_d.alu_src    = alu_src_d_i;
            de_p2_d.shift      = shift_d_i;
            de_p2_d.alu_ctrl   = alu_ctrl_d_i;
            de_p2_d.rs         = rs_p1;
            de_p2_d.rt         = rt_p1;
            de_p2_d.dest       = reg_dst_d_i ? rd_p1 : rt_p1;
            de_p2_d.shamt      = instr_p1_q[10:6];
            de_p2_d.rd1        = rd1_p1;
            de_p2_d.rd2        = rd2_p1;
            de_p2_d.imm        = imm_p1;
        end
    end

    // ---- E stage: operand forwarding (M before WB) and ALU ----
    always_comb begin
        fwd_a_p2 = de_p2_q.rd1;
        fwd_b_p2 = de_p2_q.rd2;
        if (FWD_EN) begin
            if (hits(em_p3_q.reg_write, em_p3_q.dest, de_p2_q.rs))      fwd_a_p2 = em_p3_q.alu_out;
            else if (hits(mw_p4_q.reg_write, mw_p4_q.dest, de_p2_q.rs)) fwd_a_p2 = result_p4;
            if (hits(em_p3_q.reg_write, em_p3_q.dest, de_p2_q.rt))      fwd_b_p2 = em_p3_q.alu_out;
            else if (hits(mw_p4_q.reg_write, mw_p4_q.dest, de_p2_q.rt)) fwd_b_p2 = result_p4;
        end
        src_a_p2 = de_p2_q.shift ? fwd_b_p2 : fwd_a_p2;
        if (de_p2_q.shift)        src_b_p2 = {{(DATA_W-5){1'b0}}, de_p2_q.shamt};
        else if (de_p2_q.alu_src) src_b_p2 = de_p2_q.imm;
        else                      src_b_p2 = fwd_b_p2;
    end

    always_comb begin
        em_p3_d.reg_write  = de_p2_q.reg_write;
        em_p3_d.mem_to_reg = de_p2_q.mem_to_reg;
        em_p3_d.mem_write  = de_p2_q.mem_write;
        em_p3_d.dest       = de_p2_q.dest;
        em_p3_d.alu_out    = alu(de_p2_q.alu_ctrl, src_a_p2, src_b_p2);
        em_p3_d.wdata      = fwd_b_p2;
    end

    // ---- M stage: capture memory read data ----
    always_comb begin
        mw_p4_d.reg_write  = em_p3_q.reg_write;
        mw_p4_d.mem_to_reg = em_p3_q.mem_to_reg;
        mw_p4_d.dest       = em_p3_q.dest;
        mw_p4_d.alu_out    = em_p3_q.alu_out;
        mw_p4_d.rdata      = read_data_i;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pc_q       <= RESET_PC;
            instr_p1_q <= '0;
            pc4_p1_q   <= '0;
            de_p2_q    <= '0;
            em_p3_q    <= '0;
            mw_p4_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            instr_p1_q <= instr_p1_d;
            pc4_p1_q   <= pc4_p1_d;
            de_p2_q    <= de_p2_d;
            em_p3_q    <= em_p3_d;
            mw_p4_q    <= mw_p4_d;
        end
    end

    // ---- WB stage: register file write (contents survive reset) ----
    always_ff @(posedge clk_i) begin
        if (mw_p4_q.reg_write && (mw_p4_q.dest != 5'd0))
            rf_q[mw_p4_q.dest] <= result_p4;
    end

    assign pc_o         = pc_q;
    assign instr_d_o    = instr_p1_q;
    assign alu_out_o    = em_p3_q.alu_out;
    assign write_data_o = em_p3_q.wdata;
    assign mem_write_o  = em_p3_q.mem_write;
    assign stall_o      = stall;
    assign flush_o      = flush;

endmodule

// File: tb/tb_pipe_data_path_fwd.sv
// Bench for pipe_data_path_fwd: two instances (forwarding on / off) run short
// directed programs; stores are scoreboarded, stall/flush counts and PC checked.
module tb_pipe_data_path_fwd;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] read_data;
    logic [31:0] imem [64];

    always #5 clk = ~clk;

    logic [31:0] pc1, pc2, id1, id2, ins1, ins2, alu1, alu2, wd1, wd2;
    logic        mw1, mw2, st1, st2, fl1, fl2;
    logic [11:0] c1, c2;

    // {reg_write, mem_to_reg, mem_write, alu_src, reg_dst, shift, beq, bne, j, alu_ctrl}
    function automatic logic [11:0] dec(input logic [31:0] ins);
        logic [11:0] c;
        c = '0;
        case (ins[31:26])
            6'h00: begin
                c[11] = 1'b1; c[7] = 1'b1;
                case (ins[5:0])
                    6'h20: c[2:0] = 3'd0;
                    6'h22: c[2:0] = 3'd1;
                    6'h24: c[2:0] = 3'd2;
                    6'h25: c[2:0] = 3'd3;
                    6'h26: c[2:0] = 3'd4;
                    6'h2a: c[2:0] = 3'd5;
                    6'h00: begin c[2:0] = 3'd6; c[6] = 1'b1; end
                    6'h02: begin c[2:0] = 3'd7; c[6] = 1'b1; end
                    default: c[11] = 1'b0;
                endcase
            end
            6'h08: begin c[11] = 1'b1; c[8] = 1'b1; end
            6'h23: begin c[11] = 1'b1; c[10] = 1'b1; c[8] = 1'b1; end
            6'h2b: begin c[9] = 1'b1; c[8] = 1'b1; end
            6'h04: c[5] = 1'b1;
            6'h05: c[4] = 1'b1;
            6'h02: c[3] = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    assign ins1 = imem[pc1[7:2]];
    assign ins2 = imem[pc2[7:2]];
    assign c1   = dec(id1);
    assign c2   = dec(id2);

    pipe_data_path_fwd #(.DATA_W(32), .RESET_PC(32'h0), .FWD_EN(1'b1)) dut1 (
        .clk_i(clk), .reset_i(reset_n), .instr_i(ins1), .read_data_i(read_data),
        .reg_write_d_i(c1[11]), .mem_to_reg_d_i(c1[10]), .mem_write_d_i(c1[9]),
        .alu_src_d_i(c1[8]), .reg_dst_d_i(c1[7]), .shift_d_i(c1[6]),
        .branch_eq_d_i(c1[5]), .branch_ne_d_i(c1[4]), .jump_d_i(c1[3]), .alu_ctrl_d_i(c1[2:0]),
        .pc_o(pc1), .instr_d_o(id1), .alu_out_o(alu1), .write_data_o(wd1),
        .mem_write_o(mw1), .stall_o(st1), .flush_o(fl1));

    pipe_data_path_fwd #(.DATA_W(32), .RESET_PC(32'h0), .FWD_EN(1'b0)) dut2 (
        .clk_i(clk), .reset_i(reset_n), .instr_i(ins2), .read_data_i(read_data),
        .reg_write_d_i(c2[11]), .mem_to_reg_d_i(c2[10]), .mem_write_d_i(c2[9]),
        .alu_src_d_i(c2[8]), .reg_dst_d_i(c2[7]), .shift_d_i(c2[6]),
        .branch_eq_d_i(c2[5]), .branch_ne_d_i(c2[4]), .jump_d_i(c2[3]), .alu_ctrl_d_i(c2[2:0]),
        .pc_o(pc2), .instr_d_o(id2), .alu_out_o(alu2), .write_data_o(wd2),
        .mem_write_o(mw2), .stall_o(st2), .flush_o(fl2));

    int n_chk  = 0;
    int n_fail = 0;
    int st_cnt1 = 0, st_cnt2 = 0, fl_cnt1 = 0, fl_cnt2 = 0;
    int st1_0, st2_0, fl1_0, fl2_0;
    logic [63:0] q1 [$];
    logic [63:0] q2 [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_store(input logic [31:0] addr, input logic [31:0] data);
        q1.push_back({addr, data});
        q2.push_back({addr, data});
    endtask

    // Store monitor: every store strobe pops the next expected {address, data}.
    always @(negedge clk) begin
        if (reset_n) begin
            st_cnt1 += int'(st1); st_cnt2 += int'(st2);
            fl_cnt1 += int'(fl1); fl_cnt2 += int'(fl2);
            if (mw1) begin
                if (q1.size() == 0) check("dut1_unexpected_store", {alu1, wd1}, 64'h0);
                else                check("dut1_store", {alu1, wd1}, q1.pop_front());
            end
            if (mw2) begin
                if (q2.size() == 0) check("dut2_unexpected_store", {alu2, wd2}, 64'h0);
                else                check("dut2_store", {alu2, wd2}, q2.pop_front());
            end
        end
    end

    task automatic fill(input logic [31:0] w);
        for (int i = 0; i < 64; i++) imem[i] = w;
    endtask

    task automatic start_phase();
        reset_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic release_phase();
        st1_0 = st_cnt1; st2_0 = st_cnt2; fl1_0 = fl_cnt1; fl2_0 = fl_cnt2;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic end_phase(input string tag, input int s1, input int f1, input int s2, input int f2);
        check({tag, "_dut1_pending_stores"}, q1.size(), 0);
        check({tag, "_dut2_pending_stores"}, q2.size(), 0);
        q1.delete();
        q2.delete();
        check({tag, "_dut1_stalls"}, st_cnt1 - st1_0, s1);
        check({tag, "_dut1_flushes"}, fl_cnt1 - fl1_0, f1);
        if (s2 >= 0) check({tag, "_dut2_stalls"}, st_cnt2 - st2_0, s2);
        if (f2 >= 0) check({tag, "_dut2_flushes"}, fl_cnt2 - fl2_0, f2);
    endtask

    initial begin
        bit seen;
        reset_n   = 1'b0;
        read_data = 32'h1234;
        fill(32'h0);
        repeat (3) @(negedge clk);

        // Reset state and free-running fetch
        check("rst_pc1", pc1, 32'h0);
        check("rst_alu1", alu1, 32'h0);
        check("rst_wd1", wd1, 32'h0);
        check("rst_flags1", {mw1, st1, fl1}, 3'b000);
        check("rst_pc2", pc2, 32'h0);
        reset_n = 1'b1;
        check("pc_after_release", pc1, 32'h0);
        @(negedge clk);
        check("pc_step1", pc1, 32'h4);
        check("pc_step1_flags", {st1, fl1}, 2'b00);
        @(negedge clk);
        check("pc_step2", pc1, 32'h8);
        check("pc_step2_dut2", pc2, 32'h8);

        // addi $1,$0,5 ; add $2,$1,$1 ; 3 nops ; sw $2,0($0)
        start_phase();
        fill(32'h0);
        imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        imem[1] = enc_r(5'd1, 5'd1, 5'd2, 6'h20);
        imem[5] = enc_i(6'h2b, 5'd0, 5'd2, 16'd0);
        expect_store(32'h0, 32'd10);
        release_phase();
        repeat (30) @(negedge clk);
        end_phase("raw_add", 0, 0, 3, 0);

        // lw $3,0($0) ; add $4,$3,$3 ; sw $4,8($0)
        start_phase();
        fill(32'h0);
        imem[0] = enc_i(6'h23, 5'd0, 5'd3, 16'd0);
        imem[1] = enc_r(5'd3, 5'd3, 5'd4, 6'h20);
        imem[2] = enc_i(6'h2b, 5'd0, 5'd4, 16'd8);
        expect_store(32'h8, 32'h2468);
        release_phase();
        repeat (30) @(negedge clk);
        end_phase("load_use", 1, 0, -1, -1);

        // addi $6 ; nop ; beq $0,$0,+2 @8 ; squashed/skipped stores ; bne not taken
        start_phase();
        fill(32'h0);
        imem[0] = enc_i(6'h08, 5'd0, 5'd6, 16'h11);
        imem[2] = enc_i(6'h04, 5'd0, 5'd0, 16'd2);
        imem[3] = enc_i(6'h2b, 5'd0, 5'd6, 16'h30);
        imem[4] = enc_i(6'h2b, 5'd0, 5'd6, 16'h34);
        imem[5] = enc_i(6'h2b, 5'd0, 5'd6, 16'h38);
        imem[6] = enc_i(6'h05, 5'd0, 5'd0, 16'd2);
        imem[7] = enc_i(6'h2b, 5'd0, 5'd6, 16'h3c);
        expect_store(32'h38, 32'h11);
        expect_store(32'h3c, 32'h11);
        release_phase();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (fl1) seen = 1'b1;
        end
        check("beq_flush_seen", seen, 1'b1);
        if (seen) begin
            check("beq_pc_at_flush", pc1, 32'hc);
            @(negedge clk);
            check("beq_target_pc", pc1, 32'h14);
            check("beq_flush_one_cycle", fl1, 1'b0);
        end
        repeat (25) @(negedge clk);
        end_phase("branch", 0, 1, 0, 1);

        // addi $5,$0,7 ; beq $5,$5,+1 ; squashed sw ; sw $5,0x44($0)
        start_phase();
        fill(32'h0);
        imem[0] = enc_i(6'h08, 5'd0, 5'd5, 16'd7);
        imem[1] = enc_i(6'h04, 5'd5, 5'd5, 16'd1);
        imem[2] = enc_i(6'h2b, 5'd0, 5'd5, 16'h40);
        imem[3] = enc_i(6'h2b, 5'd0, 5'd5, 16'h44);
        expect_store(32'h44, 32'd7);
        release_phase();
        repeat (30) @(negedge clk);
        end_phase("branch_operand", 1, 1, 3, 1);

        // addi $1,$0,9 ; sw $1,4($0) ; addi $7,$0,3 ; sw $7,8($0) ; addi $9 stream ; reset mid-run
        start_phase();
        fill(enc_i(6'h08, 5'd0, 5'd9, 16'h66));
        imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd9);
        imem[1] = enc_i(6'h2b, 5'd0, 5'd1, 16'd4);
        imem[2] = enc_i(6'h08, 5'd0, 5'd7, 16'd3);
        imem[3] = enc_i(6'h2b, 5'd0, 5'd7, 16'd8);
        expect_store(32'h4, 32'd9);
        expect_store(32'h8, 32'd3);
        release_phase();
        repeat (25) @(negedge clk);
        check("stream_alu1", alu1, 32'h66);
        check("stream_alu2", alu2, 32'h66);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_alu1", alu1, 32'h0);
        check("midrst_wd1", wd1, 32'h0);
        check("midrst_flags1", {mw1, st1, fl1}, 3'b000);
        check("midrst_pc1", pc1, 32'h0);
        check("midrst_dut2", {alu2, wd2}, 64'h0);
        check("midrst_pc2", pc2, 32'h0);
        @(negedge clk);
        end_phase("store_fwd", 0, 0, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
